// File: rtl/gpu_pkg.sv
// Shared GPU integer-lane definitions: default datapath width and the
// multiplier state encoding.
package gpu_pkg;

    localparam int DATA_WIDTH = 32;

    typedef enum logic [1:0] {MUL_IDLE, MUL_BUSY, MUL_DONE} mul_state_t;

endpackage

// File: rtl/add.sv
// Ripple-carry adder: {cout, sum} = a + b + cin, one full adder per bit.
module add
    import gpu_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    always_comb begin : ripple
        logic carry;
        carry = cin;
        sum   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/mul_seq.sv
// Multi-cycle unsigned shift-and-add multiplier: one partial-product
// accumulation per cycle through a single shared ripple adder.
module mul_seq
    import gpu_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] prod_lo,
    output logic [WIDTH-1:0] prod_hi
);

    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH - 1);

    mul_state_t state;
    mul_state_t next_state;

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mq;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] mq_next;

    assign addend = mq[0] ? mcand : '0;

    add #(.WIDTH(WIDTH)) u_add (
        .a    (acc),
        .b    (addend),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cout)
    );

    // {acc, mq} <= {cout, sum, mq} >> 1
    assign acc_next = {cout, sum[WIDTH-1:1]};
    assign mq_next  = {sum[0], mq[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= MUL_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        ready      = 1'b0;
        done       = 1'b0;
        case (state)
            MUL_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    next_state = MUL_BUSY;
                end
            end
            MUL_BUSY: begin
                if (cnt == '0) begin
                    next_state = MUL_DONE;
                end
            end
            MUL_DONE: begin
                done       = 1'b1;
                next_state = MUL_IDLE;
            end
            default: begin
                next_state = MUL_IDLE;
            end
        endcase
    end

    // Output registers capture the final shift on the edge that enters DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand   <= '0;
            mq      <= '0;
            acc     <= '0;
            cnt     <= '0;
            prod_lo <= '0;
            prod_hi <= '0;
        end else begin
            case (state)
                MUL_IDLE: begin
                    if (start) begin
                        mcand <= in0;
                        mq    <= in1;
                        acc   <= '0;
                        cnt   <= CNT_INIT;
                    end
                end
                MUL_BUSY: begin
                    acc <= acc_next;
                    mq  <= mq_next;
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == '0) begin
                        prod_hi <= acc_next;
                        prod_lo <= mq_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq at WIDTH=32 and WIDTH=8; expected products
// come from plain integer multiplication.
module tb_mul_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start32, start8;
    logic [31:0] in0_32, in1_32, prod_lo32, prod_hi32;
    logic [7:0]  in0_8, in1_8, prod_lo8, prod_hi8;
    logic        ready32, done32, ready8, done8;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    mul_seq #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .in0(in0_32), .in1(in1_32),
        .ready(ready32), .done(done32), .prod_lo(prod_lo32), .prod_hi(prod_hi32)
    );

    mul_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .in0(in0_8), .in1(in1_8),
        .ready(ready8), .done(done8), .prod_lo(prod_lo8), .prod_hi(prod_hi8)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with dut32 idle; returns at the negedge of the done cycle.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input bit hold,
                                 input int chg_at, input logic [31:0] a2, input logic [31:0] b2,
                                 output int lat, output int ready_bad, output logic [63:0] prod);
        start32 = 1'b1;
        in0_32  = a;
        in1_32  = b;
        @(posedge clk);
        lat       = -1;
        ready_bad = 0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (!hold && c == 1) start32 = 1'b0;
            if (c == chg_at) begin
                in0_32 = a2;
                in1_32 = b2;
            end
            if (done32 === 1'b1) begin
                lat = c;
                break;
            end
            if (ready32 !== 1'b0) ready_bad++;
        end
        prod = {prod_hi32, prod_lo32};
    endtask

    task automatic applyStimulus8(input logic [7:0] a, input logic [7:0] b,
                                  output int lat, output logic [15:0] prod);
        start8 = 1'b1;
        in0_8  = a;
        in1_8  = b;
        @(posedge clk);
        lat = -1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (c == 1) start8 = 1'b0;
            if (c == 3) begin
                in0_8 = 8'($urandom);
                in1_8 = 8'($urandom);
            end
            if (done8 === 1'b1) begin
                lat = c;
                break;
            end
        end
        prod = {prod_hi8, prod_lo8};
    endtask

    initial begin
        int          lat, rb, ndone;
        logic [63:0] prod;
        logic [15:0] prod8;
        logic [31:0] ra, rbv;
        logic [7:0]  sa, sb;

        rst = 1'b1; start32 = 1'b0; start8 = 1'b0;
        in0_32 = '0; in1_32 = '0; in0_8 = '0; in1_8 = '0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_ready", 64'(ready32), 64'd1);
        checkOutput("reset_done", 64'(done32), 64'd0);
        checkOutput("reset_prod", {prod_hi32, prod_lo32}, 64'd0);
        checkOutput("reset_ready8", 64'(ready8), 64'd1);
        rst = 1'b0;
        @(negedge clk);

        // 3 x 5, with operands scrambled mid-flight
        applyStimulus(32'd3, 32'd5, 1'b0, 4, 32'hABCD_1234, 32'h5555_AAAA, lat, rb, prod);
        checkOutput("3x5_latency", 64'(lat), 64'd33);
        checkOutput("3x5_ready_low", 64'(rb), 64'd0);
        checkOutput("3x5_prod", prod, 64'h0000_0000_0000_000F);
        @(negedge clk);
        checkOutput("3x5_ready_back", 64'(ready32), 64'd1);
        checkOutput("3x5_done_single", 64'(done32), 64'd0);
        checkOutput("3x5_prod_hold", {prod_hi32, prod_lo32}, 64'h0000_0000_0000_000F);

        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, '0, '0, lat, rb, prod);
        checkOutput("max_prod", prod, 64'hFFFF_FFFE_0000_0001);
        @(negedge clk);
        applyStimulus(32'd0, 32'hDEAD_BEEF, 1'b0, 0, '0, '0, lat, rb, prod);
        checkOutput("zero_prod", prod, 64'd0);
        @(negedge clk);

        // 7 x 9 with start held; the held start launches 2 x 2 at cycle 34
        applyStimulus(32'd7, 32'd9, 1'b1, 5, 32'd2, 32'd2, lat, rb, prod);
        checkOutput("hold_latency", 64'(lat), 64'd33);
        checkOutput("hold_prod", prod, 64'd63);
        @(negedge clk);
        checkOutput("hold_c34_ready", 64'(ready32), 64'd1);
        checkOutput("hold_c34_done", 64'(done32), 64'd0);
        lat = -1;
        for (int c = 35; c <= 90; c++) begin
            @(negedge clk);
            if (c == 35) start32 = 1'b0;
            if (done32 === 1'b1) begin
                lat = c;
                break;
            end
        end
        checkOutput("second_done_cycle", 64'(lat), 64'd67);
        checkOutput("second_prod", {prod_hi32, prod_lo32}, 64'd4);
        @(negedge clk);

        // reset in cycle 10 abandons the multiply
        start32 = 1'b1; in0_32 = 32'h1234; in1_32 = 32'h5678;
        @(posedge clk);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) start32 = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst_ready", 64'(ready32), 64'd1);
        checkOutput("midrst_prod", {prod_hi32, prod_lo32}, 64'd0);
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            if (done32 !== 1'b0) ndone++;
            @(negedge clk);
        end
        checkOutput("midrst_no_done", 64'(ndone), 64'd0);
        applyStimulus(32'h1234, 32'h5678, 1'b0, 0, '0, '0, lat, rb, prod);
        checkOutput("fresh_prod", prod, 64'h0000_0000_0626_0060);
        @(negedge clk);

        // reset and start together: reset wins
        applyStimulus(32'd3, 32'd5, 1'b0, 0, '0, '0, lat, rb, prod);
        checkOutput("pre_rst_prod", prod, 64'h0F);
        @(negedge clk);
        rst = 1'b1; start32 = 1'b1; in0_32 = 32'd6; in1_32 = 32'd7;
        @(negedge clk);
        rst = 1'b0; start32 = 1'b0;
        checkOutput("rststart_ready", 64'(ready32), 64'd1);
        checkOutput("rststart_prod", {prod_hi32, prod_lo32}, 64'd0);
        @(negedge clk);
        checkOutput("rststart_no_accept", 64'(ready32), 64'd1);

        for (int i = 0; i < 40; i++) begin
            ra  = $urandom;
            rbv = $urandom;
            applyStimulus(ra, rbv, 1'b0, 2 + (i % 30), $urandom, $urandom, lat, rb, prod);
            checkOutput("rand32_prod", prod, 64'(ra) * 64'(rbv));
            @(negedge clk);
        end

        applyStimulus8(8'd200, 8'd250, lat, prod8);
        checkOutput("w8_latency", 64'(lat), 64'd9);
        checkOutput("w8_prod", 64'(prod8), 64'hC350);
        @(negedge clk);
        for (int i = 0; i < 500; i++) begin
            sa = 8'($urandom);
            sb = 8'($urandom);
            applyStimulus8(sa, sb, lat, prod8);
            checkOutput("rand8_prod", 64'(prod8), 64'(16'(sa) * 16'(sb)));
            if (lat != 9) checkOutput("rand8_latency", 64'(lat), 64'd9);
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
